// File: rtl/wb_burst_adr_tracker_if.sv
// Wishbone B3 slave-side request signals observed by the burst address tracker.
interface wb_burst_adr_tracker_if #(
    parameter int unsigned aw = 32
) ();
    logic [aw-1:0] wb_adr_i;
    logic [2:0]    wb_cti_i;
    logic [1:0]    wb_bte_i;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic          wb_ack_i;

    modport master (
        output wb_adr_i, wb_cti_i, wb_bte_i, wb_cyc_i, wb_stb_i, wb_ack_i
    );

    modport slave (
        input wb_adr_i, wb_cti_i, wb_bte_i, wb_cyc_i, wb_stb_i, wb_ack_i
    );
endinterface

// File: rtl/wb_burst_adr_tracker.sv
// Wishbone B3 burst address tracker: predicts the next beat address (linear or
// 4/8/16-beat wrap), counts beats and flags illegal burst changes and address mismatches.
module wb_burst_adr_tracker #(
    parameter int unsigned aw        = 32,
    parameter int unsigned dw        = 32,
    parameter bit          check_adr = 1'b1
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    wb_burst_adr_tracker_if.slave  wb,
    output logic [aw-1:0]          mem_adr_o,
    output logic                   burst_o,
    output logic [4:0]             beat_cnt_o,
    output logic                   wrap_o,
    output logic                   err_o,
    output logic                   mismatch_o
);

    localparam int unsigned STEP    = dw / 8;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned CNT_MAX = 31;

    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_EOB  = 3'b111;
    localparam logic [1:0] BTE_LIN  = 2'b00;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [aw-1:0]    adr_q, adr_d;
    logic [1:0]       bte_q, bte_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             mis_q, mis_d;

    logic             beat_ok;
    logic             bad_type;
    logic [aw-1:0]    nxt_in;
    logic [aw-1:0]    nxt_q;
    logic [CNT_W-1:0] cnt_inc;

    // Bits inside the wrap span; all ones for a linear burst so next() is a plain add.
    function automatic logic [aw-1:0] span_mask(input logic [1:0] bte);
        case (bte)
            2'b01:   return aw'(4 * STEP - 1);
            2'b10:   return aw'(8 * STEP - 1);
            2'b11:   return aw'(16 * STEP - 1);
            default: return '1;
        endcase
    endfunction

    function automatic logic [aw-1:0] next_adr(input logic [aw-1:0] a, input logic [1:0] bte);
        logic [aw-1:0] mask;
        logic [aw-1:0] sum;
        mask = span_mask(bte);
        sum  = a + aw'(STEP);
        return (a & ~mask) | (sum & mask);
    endfunction

    function automatic logic crossed(input logic [aw-1:0] a, input logic [1:0] bte);
        return (bte != BTE_LIN) && ((a & span_mask(bte)) == '0);
    endfunction

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        bte_d    = bte_q;
        cnt_d    = cnt_q;
        wrap_d   = 1'b0;
        err_d    = 1'b0;
        mis_d    = 1'b0;
        beat_ok  = wb.wb_cyc_i & wb.wb_stb_i & wb.wb_ack_i;
        bad_type = ((wb.wb_cti_i != CTI_INCR) && (wb.wb_cti_i != CTI_EOB)) ||
                   (wb.wb_bte_i != bte_q);
        nxt_in   = next_adr(wb.wb_adr_i, wb.wb_bte_i);
        nxt_q    = next_adr(adr_q, bte_q);
        cnt_inc  = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (beat_ok) begin
                    if (wb.wb_cti_i == CTI_INCR) begin
                        state_d = ST_BURST;
                        adr_d   = nxt_in;
                        bte_d   = wb.wb_bte_i;
                        cnt_d   = CNT_W'(1);
                        wrap_d  = crossed(nxt_in, wb.wb_bte_i);
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            ST_BURST: begin
                // Abort outranks error; wait states fall through and hold everything.
                if (!wb.wb_cyc_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (beat_ok) begin
                    mis_d = check_adr && (wb.wb_adr_i != adr_q);
                    if (bad_type) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else if (wb.wb_cti_i == CTI_EOB) begin
                        state_d = ST_IDLE;
                        cnt_d   = cnt_inc;
                    end else begin
                        adr_d  = nxt_q;
                        cnt_d  = cnt_inc;
                        wrap_d = crossed(nxt_q, bte_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            bte_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            bte_q   <= bte_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    // Pass-through while idle so the first beat reaches memory without added latency.
    assign mem_adr_o  = (state_q == ST_BURST) ? adr_q : wb.wb_adr_i;
    assign burst_o    = (state_q == ST_BURST);
    assign beat_cnt_o = cnt_q;
    assign wrap_o     = wrap_q;
    assign err_o      = err_q;
    assign mismatch_o = mis_q;

endmodule

// File: tb/tb_wb_burst_adr_tracker.sv
// Directed bench for wb_burst_adr_tracker: a dw=32 and a dw=64 instance driven in parallel.
module tb_wb_burst_adr_tracker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wb_burst_adr_tracker_if #(.aw(32)) if32 ();
    wb_burst_adr_tracker_if #(.aw(32)) if64 ();

    logic [31:0] mem32, mem64;
    logic [4:0]  cnt32, cnt64;
    logic        burst32, wrap32, err32, mis32;
    logic        burst64, wrap64, err64, mis64;

    wb_burst_adr_tracker #(.aw(32), .dw(32), .check_adr(1'b1)) u_dut32 (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb         (if32.slave),
        .mem_adr_o  (mem32),
        .burst_o    (burst32),
        .beat_cnt_o (cnt32),
        .wrap_o     (wrap32),
        .err_o      (err32),
        .mismatch_o (mis32)
    );

    wb_burst_adr_tracker #(.aw(32), .dw(64), .check_adr(1'b1)) u_dut64 (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb         (if64.slave),
        .mem_adr_o  (mem64),
        .burst_o    (burst64),
        .beat_cnt_o (cnt64),
        .wrap_o     (wrap64),
        .err_o      (err64),
        .mismatch_o (mis64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of bus inputs to both instances, then return mid-cycle for sampling.
    task automatic drv(input logic cyc, input logic stb, input logic ack,
                       input logic [31:0] adr, input logic [2:0] cti, input logic [1:0] bte);
        @(posedge clk);
        #1;
        if32.wb_cyc_i = cyc; if32.wb_stb_i = stb; if32.wb_ack_i = ack;
        if32.wb_adr_i = adr; if32.wb_cti_i = cti; if32.wb_bte_i = bte;
        if64.wb_cyc_i = cyc; if64.wb_stb_i = stb; if64.wb_ack_i = ack;
        if64.wb_adr_i = adr; if64.wb_cti_i = cti; if64.wb_bte_i = bte;
        @(negedge clk);
    endtask

    task automatic beat(input logic [31:0] adr, input logic [2:0] cti, input logic [1:0] bte);
        drv(1'b1, 1'b1, 1'b1, adr, cti, bte);
    endtask

    task automatic idle(input logic [31:0] adr);
        drv(1'b0, 1'b0, 1'b0, adr, 3'b000, 2'b00);
    endtask

    initial begin
        // Reset state
        idle(32'h0);
        idle(32'h123);
        chk("rst_mem", mem32, 32'h123);
        chk("rst_burst", burst32, 1'b0);
        chk("rst_cnt", cnt32, 5'd0);
        chk("rst_pulses", {wrap32, err32, mis32}, 3'b000);
        rst = 1'b0;

        // Linear burst at 0x100, four beats
        beat(32'h100, 3'b010, 2'b00);
        chk("lin_b0_mem", mem32, 32'h100);
        chk("lin_b0_burst", burst32, 1'b0);
        beat(32'h104, 3'b010, 2'b00);
        chk("lin_b1_mem", mem32, 32'h104);
        chk("lin_b1_cnt", cnt32, 5'd1);
        chk("lin_b1_burst", burst32, 1'b1);
        beat(32'h108, 3'b010, 2'b00);
        chk("lin_b2_mem", mem32, 32'h108);
        chk("lin_b2_cnt", cnt32, 5'd2);
        beat(32'h10C, 3'b111, 2'b00);
        chk("lin_b3_mem", mem32, 32'h10C);
        chk("lin_b3_cnt", cnt32, 5'd3);
        chk("lin_b3_wrap", wrap32, 1'b0);
        idle(32'h0);
        chk("lin_end_cnt", cnt32, 5'd4);
        chk("lin_end_burst", burst32, 1'b0);

        // WRAP4 at 0x1C, dw=32
        beat(32'h1C, 3'b010, 2'b01);
        chk("w4_b0_mem", mem32, 32'h1C);
        beat(32'h10, 3'b010, 2'b01);
        chk("w4_b1_mem", mem32, 32'h10);
        chk("w4_b1_wrap", wrap32, 1'b1);
        beat(32'h14, 3'b010, 2'b01);
        chk("w4_b2_mem", mem32, 32'h14);
        chk("w4_b2_wrap", wrap32, 1'b0);
        beat(32'h18, 3'b111, 2'b01);
        chk("w4_b3_mem", mem32, 32'h18);
        chk("w4_b3_wrap", wrap32, 1'b0);
        idle(32'h0);
        chk("w4_end_cnt", cnt32, 5'd4);
        chk("w4_end_wrap", wrap32, 1'b0);

        // WRAP8 at 0x238, dw=64
        beat(32'h238, 3'b010, 2'b10);
        chk("w8_b0_mem", mem64, 32'h238);
        beat(32'h200, 3'b010, 2'b10);
        chk("w8_b1_mem", mem64, 32'h200);
        chk("w8_b1_wrap", wrap64, 1'b1);
        beat(32'h208, 3'b010, 2'b10);
        chk("w8_b2_mem", mem64, 32'h208);
        chk("w8_b2_wrap", wrap64, 1'b0);
        beat(32'h210, 3'b111, 2'b10);
        chk("w8_b3_mem", mem64, 32'h210);
        idle(32'h0);
        chk("w8_end_cnt", cnt64, 5'd4);
        chk("w8_end_burst", burst64, 1'b0);

        // Wait states between beats 2 and 3
        beat(32'h200, 3'b010, 2'b00);
        beat(32'h204, 3'b010, 2'b00);
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 1'b1, 1'b0, 32'h208, 3'b010, 2'b00);
            chk("ws_hold_mem", mem32, 32'h208);
            chk("ws_hold_cnt", cnt32, 5'd2);
        end
        beat(32'h208, 3'b010, 2'b00);
        chk("ws_b2_mem", mem32, 32'h208);
        beat(32'h20C, 3'b111, 2'b00);
        chk("ws_b3_mem", mem32, 32'h20C);
        chk("ws_b3_cnt", cnt32, 5'd3);
        idle(32'h0);
        chk("ws_end_cnt", cnt32, 5'd4);

        // bte change on beat 3 -> error
        beat(32'h40, 3'b010, 2'b01);
        beat(32'h44, 3'b010, 2'b01);
        beat(32'h48, 3'b010, 2'b10);
        chk("bte_b2_mem", mem32, 32'h48);
        chk("bte_b2_err", err32, 1'b0);
        idle(32'h0);
        chk("bte_err", err32, 1'b1);
        chk("bte_burst", burst32, 1'b0);
        idle(32'h0);
        chk("bte_err_clr", err32, 1'b0);

        // cyc drop mid-burst -> abort without error
        beat(32'h80, 3'b010, 2'b00);
        beat(32'h84, 3'b010, 2'b00);
        idle(32'h0);
        chk("abt_pre_cnt", cnt32, 5'd2);
        idle(32'h0);
        chk("abt_burst", burst32, 1'b0);
        chk("abt_cnt", cnt32, 5'd0);
        chk("abt_err", err32, 1'b0);

        // Address mismatch: 0x108 sent where 0x104 predicted
        beat(32'h100, 3'b010, 2'b00);
        beat(32'h108, 3'b010, 2'b00);
        chk("mis_b1_mem", mem32, 32'h104);
        chk("mis_b1_flag", mis32, 1'b0);
        beat(32'h108, 3'b010, 2'b00);
        chk("mis_flag", mis32, 1'b1);
        chk("mis_next_mem", mem32, 32'h108);
        beat(32'h10C, 3'b111, 2'b00);
        chk("mis_clr", mis32, 1'b0);
        chk("mis_b3_mem", mem32, 32'h10C);
        idle(32'h0);
        chk("mis_end_cnt", cnt32, 5'd4);

        // Linear rollover modulo 2^aw
        beat(32'hFFFF_FFFC, 3'b010, 2'b00);
        beat(32'h0, 3'b111, 2'b00);
        chk("roll_mem", mem32, 32'h0);
        chk("roll_wrap", wrap32, 1'b0);
        idle(32'h0);

        // Reset mid-burst
        beat(32'h300, 3'b010, 2'b00);
        beat(32'h304, 3'b010, 2'b00);
        chk("rmid_burst", burst32, 1'b1);
        rst = 1'b1;
        idle(32'h55C);
        chk("rmid_mem", mem32, 32'h55C);
        chk("rmid_burst0", burst32, 1'b0);
        chk("rmid_cnt", cnt32, 5'd0);
        chk("rmid_pulses", {wrap32, err32, mis32}, 3'b000);
        rst = 1'b0;
        idle(32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
